cw305_ct_capture: RTL
=====================

Name: cw305_ct_capture

Overview:
- Downstream of the crypto core on the CW305 Artix-7 target.
- Watches the core's busy strobe and latches the 128-bit ciphertext on busy's falling edge.
- Counts the cycles busy was high and exposes ciphertext, count and status to the host register bus as byte-addressed reads.
- Drives a registered scope trigger that is high while the core is busy.

Parameters:
- CT_WIDTH, 128, ciphertext width in bits; must be a multiple of 8; number of ciphertext bytes NB = CT_WIDTH/8.
- CNT_WIDTH, 32, busy-cycle counter width in bits; must be a multiple of 8; NC = CNT_WIDTH/8.

Ports:
- clk  in  1  single clock shared with the crypto core.
- rst  in  1  reset; asynchronous, active-high.
- busy_in  in  1  busy from the crypto core.
- ct_in  in  CT_WIDTH  ciphertext from the crypto core; valid in the first cycle busy_in is low after being high.
- rd_en  in  1  host read strobe, one cycle per read.
- rd_addr  in  8  host byte address.
- rd_data  out  8  read data.
- rd_valid  out  1  high for one cycle when rd_data is valid.
- done  out  1  a capture is held and its status has not yet been read.
- overrun  out  1  a new capture arrived while done was still set.
- trig_out  out  1  scope trigger, equal to busy_in delayed by one register.

Behaviour:
- Reset values: rd_data=0, rd_valid=0, done=0, overrun=0, trig_out=0, ct_reg=0, cnt_reg=0, FSM=IDLE.
- Reset is asynchronous and may assert mid-operation; a capture in progress is discarded.
- FSM has two states, IDLE and RUN.
- IDLE, busy_in=1: go to RUN and set the running count to 1. No edge detector is needed; entering RUN is the rising edge.
- RUN, busy_in=1: running count += 1, saturating at all-ones (no wrap).
- RUN, busy_in=0 (capture cycle): ct_reg<=ct_in, cnt_reg<=running count, go to IDLE.
- Consequence: a 1-cycle busy pulse gives count=1, and the core's ciphertext present in the falling cycle is latched.
- ct_reg and cnt_reg hold until the next capture; the running count never disturbs cnt_reg.
- Let sr = rd_en & (rd_addr==STATUS_ADDR).
- done_next = capture | (done & ~sr).
- overrun_next = (capture & done & ~sr) | (overrun & ~sr).
- When a capture and a status read occur in the same cycle, the read returns the pre-capture flags, and done=1, overrun=0 afterwards.
- Read latency is 1 cycle: rd_en at cycle N gives rd_valid=1 and rd_data at N+1.
- Without rd_en, rd_valid=0 and rd_data holds its last value.
- A read in the same cycle as a capture returns the old ct_reg/cnt_reg.
- Address map:
  - 0..NB-1: ct bytes, big-endian (addr 0 = ct_reg[CT_WIDTH-1 -: 8]).
  - NB..NB+NC-1: cnt_reg bytes, little-endian (addr NB = cnt_reg[7:0]).
  - STATUS_ADDR = NB+NC: {6'b0, overrun, done}.
  - Any other address: reads 0, no side effects.
- trig_out <= busy_in every cycle.
- busy_in is synchronous to clk; no synchronizer is required.

Decomposition:
- Shared package cw305_pkg holds:
  - the FSM state enum (IDLE, RUN);
  - address constants CT_BASE=0, CNT_BASE=NB, STATUS_ADDR=NB+NC;
  - status bit indices DONE_BIT=0, OVERRUN_BIT=1.
- One natural sub-module: cw305_rd_mux, the registered byte-select read mux with rd_valid generation.
- The FSM, counter and flags stay in the top level.

Test Plan:
- Reset: assert rst mid-RUN with busy_in=1 -> all outputs 0 immediately; after release, a read of addr 20 returns 0x00.
- Single-cycle op: busy_in high 1 cycle, ct_in=0xdeadbeef repeated 4 times in the falling cycle -> done=1; addr 0..3 read DE AD BE EF; addr 16 reads 0x01 and addr 17..19 read 0; the status read returns 0x01 and then done=0.
- Long op: busy_in high 1000 cycles -> addr 16=0xE8, addr 17=0x03; trig_out is high for exactly 1000 cycles, lagging busy_in by 1 cycle.
- Overrun: two captures with no status read -> status reads 0x03 and holds the second ct; the next status read returns 0x00.
- Collision: a status read in the capture cycle -> rd_data returns 0x00, and afterwards done=1, overrun=0.
- Read handshake: rd_en to addr 0x55 -> rd_valid is a single-cycle pulse at N+1 with rd_data=0x00; back-to-back rd_en on addr 0,1 -> consecutive valid bytes.

Source files
------------

// File: rtl/cw305_pkg.sv
// Shared types and address-map constants for the CW305 ciphertext capture block.
package cw305_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int DONE_BIT      = 0;
   localparam int OVERRUN_BIT   = 1;

   localparam int DEF_CT_WIDTH  = 128;
   localparam int DEF_CNT_WIDTH = 32;

   localparam int CT_BASE       = 0;
   localparam int CNT_BASE      = CT_BASE + DEF_CT_WIDTH / 8;
   localparam int STATUS_ADDR   = CNT_BASE + DEF_CNT_WIDTH / 8;

   // Address map for non-default widths: counter bytes follow the ciphertext bytes.
   function automatic int cnt_base(input int nb);
      return CT_BASE + nb;
   endfunction

   function automatic int status_addr(input int nb, input int nc);
      return CT_BASE + nb + nc;
   endfunction

endpackage

// File: rtl/cw305_rd_mux.sv
// Registered byte-select read mux for the host bus: one-cycle latency,
// rd_valid pulses with each read, rd_data holds between reads.
module cw305_rd_mux
   import cw305_pkg::*;
#(
   parameter int CT_WIDTH  = 128,
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rd_en,
   input  logic [7:0]           rd_addr,
   input  logic [CT_WIDTH-1:0]  ct_reg,
   input  logic [CNT_WIDTH-1:0] cnt_reg,
   input  logic [7:0]           status,
   output logic [7:0]           rd_data,
   output logic                 rd_valid
);

   localparam int NB            = CT_WIDTH / 8;
   localparam int NC            = CNT_WIDTH / 8;
   localparam int LP_CNT_BASE   = cnt_base(NB);
   localparam int LP_STATUS     = status_addr(NB, NC);

   logic [7:0] w_byte;
   logic [7:0] r_data;
   logic       r_valid;

   // Addresses are disjoint, so OR-ing the gated bytes selects exactly one (or none -> 0).
   always_comb begin
      w_byte = 8'h00;
      for (int i = 0; i < NB; i++) begin
         w_byte = w_byte | ((rd_addr == 8'(CT_BASE + i)) ? ct_reg[CT_WIDTH-1-8*i -: 8] : 8'h00);
      end
      for (int j = 0; j < NC; j++) begin
         w_byte = w_byte | ((rd_addr == 8'(LP_CNT_BASE + j)) ? cnt_reg[8*j +: 8] : 8'h00);
      end
      w_byte = w_byte | ((rd_addr == 8'(LP_STATUS)) ? status : 8'h00);
   end

   // Read data/valid registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_data  <= 8'h00;
         r_valid <= 1'b0;
      end else begin
         r_valid <= rd_en;
         if (rd_en) begin
            r_data <= w_byte;
         end
      end
   end

   assign rd_data  = r_data;
   assign rd_valid = r_valid;

endmodule

// File: rtl/cw305_ct_capture.sv
// Latches the crypto core's ciphertext on busy's falling edge, counts busy
// cycles, keeps done/overrun status and drives a registered scope trigger.
module cw305_ct_capture
   import cw305_pkg::*;
#(
   parameter int CT_WIDTH  = 128,
   parameter int CNT_WIDTH = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                busy_in,
   input  logic [CT_WIDTH-1:0] ct_in,
   input  logic                rd_en,
   input  logic [7:0]          rd_addr,
   output logic [7:0]          rd_data,
   output logic                rd_valid,
   output logic                done,
   output logic                overrun,
   output logic                trig_out
);

   localparam int NB             = CT_WIDTH / 8;
   localparam int NC             = CNT_WIDTH / 8;
   localparam int LP_STATUS_ADDR = status_addr(NB, NC);

   state_t               r_state;
   state_t               w_state_next;
   logic [CNT_WIDTH-1:0] r_run_cnt;
   logic [CNT_WIDTH-1:0] w_run_cnt_next;
   logic [CT_WIDTH-1:0]  r_ct;
   logic [CNT_WIDTH-1:0] r_cnt;
   logic                 r_done;
   logic                 r_overrun;
   logic                 r_trig;
   logic                 w_capture;
   logic                 w_sr;
   logic                 w_done_next;
   logic                 w_overrun_next;
   logic [7:0]           w_status;

   // Entering RUN is itself the rising edge of busy, so no edge detector is kept.
   always_comb begin
      w_state_next   = r_state;
      w_run_cnt_next = r_run_cnt;
      w_capture      = 1'b0;
      case (r_state)
         IDLE: begin
            if (busy_in) begin
               w_state_next   = RUN;
               w_run_cnt_next = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
         end
         RUN: begin
            if (busy_in) begin
               w_run_cnt_next = (r_run_cnt == {CNT_WIDTH{1'b1}}) ? r_run_cnt
                                                                 : r_run_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end else begin
               w_capture    = 1'b1;
               w_state_next = IDLE;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   // Status flags: a status read clears them, a capture re-arms done.
   always_comb begin
      w_sr           = rd_en & (rd_addr == 8'(LP_STATUS_ADDR));
      w_done_next    = w_capture | (r_done & ~w_sr);
      w_overrun_next = (w_capture & r_done & ~w_sr) | (r_overrun & ~w_sr);
      w_status                = 8'h00;
      w_status[DONE_BIT]      = r_done;
      w_status[OVERRUN_BIT]   = r_overrun;
   end

   // FSM state and running busy-cycle count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_run_cnt <= {CNT_WIDTH{1'b0}};
      end else begin
         r_state   <= w_state_next;
         r_run_cnt <= w_run_cnt_next;
      end
   end

   // Captured ciphertext and count, held until the next capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ct  <= {CT_WIDTH{1'b0}};
         r_cnt <= {CNT_WIDTH{1'b0}};
      end else if (w_capture) begin
         r_ct  <= ct_in;
         r_cnt <= r_run_cnt;
      end
   end

   // Flag and trigger registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_done    <= 1'b0;
         r_overrun <= 1'b0;
         r_trig    <= 1'b0;
      end else begin
         r_done    <= w_done_next;
         r_overrun <= w_overrun_next;
         r_trig    <= busy_in;
      end
   end

   cw305_rd_mux #(
      .CT_WIDTH  (CT_WIDTH),
      .CNT_WIDTH (CNT_WIDTH)
   ) u_rd_mux (
      .clk      (clk),
      .rst      (rst),
      .rd_en    (rd_en),
      .rd_addr  (rd_addr),
      .ct_reg   (r_ct),
      .cnt_reg  (r_cnt),
      .status   (w_status),
      .rd_data  (rd_data),
      .rd_valid (rd_valid)
   );

   assign done     = r_done;
   assign overrun  = r_overrun;
   assign trig_out = r_trig;

endmodule
